// File: rtl/router_pkg.sv
// ---------------------------------------------------------------------------
// router_pkg
// Shared types and helpers for the router arbitration blocks.
//   sched_state_t : scheduler FSM states (IDLE waits for a requester,
//                   BURST forwards words from the granted FIFO)
//   clog2         : ceiling log2 with a floor of 1. Every index or counter
//                   built from it is at least one bit wide.
// ---------------------------------------------------------------------------
package router_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } sched_state_t;

  // Smallest width (minimum 1) that can hold values 0 .. value-1.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker shared by the router arbiters.
// Returns the first requesting index found by scanning ptr, ptr+1, ...
// modulo NUM_IN.
//   req_i     : request vector, bit i = requester i
//   ptr_i     : index with highest priority this cycle
//   gnt_idx_o : chosen index (equals ptr_i when nothing requests)
//   any_o     : at least one request is present
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int NUM_IN = 4,
  parameter int PTR_W  = 2
) (
  input  logic [NUM_IN-1:0] req_i,
  input  logic [PTR_W-1:0]  ptr_i,
  output logic [PTR_W-1:0]  gnt_idx_o,
  output logic              any_o
);

  logic [PTR_W-1:0] candIdx;

  // Walk the offsets from farthest to nearest. The last match written is
  // then the requester closest to ptr_i in round-robin order.
  always_comb begin
    gnt_idx_o = ptr_i;
    candIdx   = '0;
    any_o     = |req_i;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      candIdx = PTR_W'((int'(ptr_i) + k) % NUM_IN);
      if (req_i[candIdx]) begin
        gnt_idx_o = candIdx;
      end
    end
  end

endmodule

// File: rtl/buffer_rr_scheduler.sv
// ---------------------------------------------------------------------------
// buffer_rr_scheduler
// Shares one output link among NUM_IN input FIFOs. One FIFO is granted in
// round-robin order. The scheduler pops up to BURST_LEN words from it into a
// registered valid/ready output stage and then re-arbitrates. Holding the
// grant for a whole burst keeps multi-flit messages contiguous.
//   clk_i          : clock
//   rst_i          : synchronous, active-high reset
//   fifo_empty_i   : per-FIFO empty flag
//   fifo_data_i    : per-FIFO head word, FIFO i at [i*DATA_WIDTH +: DATA_WIDTH]
//   fifo_consume_o : pop strobe, one-hot or zero
//   out_data_o     : registered forwarded word
//   out_valid_o    : out_data_o holds a word
//   out_src_o      : FIFO index that supplied out_data_o
//   out_ready_i    : downstream accepts out_data_o this cycle
//   busy_o         : a grant is active
// ---------------------------------------------------------------------------
module buffer_rr_scheduler
  import router_pkg::*;
#(
  parameter int NUM_IN     = 4,
  parameter int DATA_WIDTH = 64,
  parameter int BURST_LEN  = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_IN-1:0]            fifo_empty_i,
  input  logic [NUM_IN*DATA_WIDTH-1:0] fifo_data_i,
  output logic [NUM_IN-1:0]            fifo_consume_o,
  output logic [DATA_WIDTH-1:0]        out_data_o,
  output logic                         out_valid_o,
  output logic [clog2(NUM_IN)-1:0]     out_src_o,
  input  logic                         out_ready_i,
  output logic                         busy_o
);

  localparam int PTR_W = clog2(NUM_IN);
  localparam int CNT_W = clog2(BURST_LEN + 1);

  sched_state_t          state_q;
  logic [PTR_W-1:0]      rrPtr_q;
  logic [PTR_W-1:0]      rrPtr_d;
  logic [PTR_W-1:0]      grant_q;
  logic [CNT_W-1:0]      burstCnt_q;
  logic [CNT_W-1:0]      burstCnt_d;
  logic                  outValid_q;
  logic [DATA_WIDTH-1:0] outData_q;
  logic [PTR_W-1:0]      outSrc_q;

  logic                  canLoad;
  logic                  grantEmpty;
  logic                  pop;
  logic [PTR_W-1:0]      pickIdx;
  logic                  pickAny;
  logic [DATA_WIDTH-1:0] fifoWord [NUM_IN];

  // The picker only runs while idle. The empty flags are inverted into
  // request lines, and the scan starts at the round-robin pointer.
  rr_pick #(
    .NUM_IN (NUM_IN),
    .PTR_W  (PTR_W)
  ) u_pick (
    .req_i     (~fifo_empty_i),
    .ptr_i     (rrPtr_q),
    .gnt_idx_o (pickIdx),
    .any_o     (pickAny)
  );

  // Split the flattened head-word bus into an array. The granted FIFO's
  // word can then be selected with a plain index.
  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      fifoWord[i] = fifo_data_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Pop decision for the current cycle. The FIFO head is combinational, so
  // the consume strobe and the data capture happen on the same edge. Reset
  // masks the strobe so that no word is lost while the grant is dropped.
  always_comb begin
    canLoad        = ~outValid_q | out_ready_i;
    grantEmpty     = fifo_empty_i[grant_q];
    pop            = (state_q == BURST) & canLoad & ~grantEmpty & ~rst_i;
    burstCnt_d     = burstCnt_q + 1'b1;
    rrPtr_d        = (grant_q == PTR_W'(NUM_IN - 1)) ? '0 : grant_q + 1'b1;
    fifo_consume_o = pop ? (NUM_IN'(1) << grant_q) : '0;
  end

  // Scheduler FSM plus output register. A pop always refills the output
  // stage, even when the current word is leaving in the same cycle. The
  // stage empties only when its word is taken and nothing replaces it. The
  // grant is released when the burst quota is reached, or when the source
  // turns out to be empty in a cycle where a word could have been taken.
  // A stalled output simply freezes everything.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rrPtr_q    <= '0;
      grant_q    <= '0;
      burstCnt_q <= '0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outSrc_q   <= '0;
    end else begin
      if (pop) begin
        outData_q  <= fifoWord[grant_q];
        outSrc_q   <= grant_q;
        outValid_q <= 1'b1;
      end else if (outValid_q && out_ready_i) begin
        outValid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (pickAny) begin
            grant_q    <= pickIdx;
            burstCnt_q <= '0;
            state_q    <= BURST;
          end
        end
        BURST: begin
          if (pop) begin
            burstCnt_q <= burstCnt_d;
            if (burstCnt_d == CNT_W'(BURST_LEN)) begin
              state_q <= IDLE;
              rrPtr_q <= rrPtr_d;
            end
          end else if (canLoad && grantEmpty) begin
            state_q <= IDLE;
            rrPtr_q <= rrPtr_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_data_o  = outData_q;
  assign out_valid_o = outValid_q;
  assign out_src_o   = outSrc_q;
  assign busy_o      = (state_q == BURST);

endmodule

// File: tb/tb_buffer_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_buffer_rr_scheduler
// Self-checking bench for buffer_rr_scheduler (NUM_IN=4, BURST_LEN=4).
// The bench models the FIFOs as small arrays. Every word that should appear
// on the output link goes into a scoreboard queue, in the order the
// arbitration should produce it.
// Words are tagged {src, test, seq}, which keeps a lost, duplicated or
// reordered word visible.
// ---------------------------------------------------------------------------
module tb_buffer_rr_scheduler;

  localparam int NUM_IN = 4;
  localparam int DW     = 64;
  localparam int BLEN   = 4;
  localparam int DEPTH  = 32;

  logic              clk_i;
  logic              rst_i;
  logic [NUM_IN-1:0] fifo_empty_i;
  logic [NUM_IN*DW-1:0] fifo_data_i;
  logic [NUM_IN-1:0] fifo_consume_o;
  logic [DW-1:0]     out_data_o;
  logic              out_valid_o;
  logic [1:0]        out_src_o;
  logic              out_ready_i;
  logic              busy_o;

  logic [DW-1:0] fifoMem [NUM_IN][DEPTH];
  int            fifoHead [NUM_IN];
  int            fifoCnt  [NUM_IN];
  logic [DW-1:0] expQ [$];

  logic [NUM_IN-1:0] lastConsume;
  logic              lastValid;
  logic              lastBusy;
  logic [DW-1:0]     lastData;

  int checkCount;
  int passCount;

  buffer_rr_scheduler #(
    .NUM_IN     (NUM_IN),
    .DATA_WIDTH (DW),
    .BURST_LEN  (BLEN)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .fifo_empty_i   (fifo_empty_i),
    .fifo_data_i    (fifo_data_i),
    .fifo_consume_o (fifo_consume_o),
    .out_data_o     (out_data_o),
    .out_valid_o    (out_valid_o),
    .out_src_o      (out_src_o),
    .out_ready_i    (out_ready_i),
    .busy_o         (busy_o)
  );

  // Free-running 10-unit clock.
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Hard stop in case something stalls the main sequence.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    checkCount++;
    if (observed !== expected) begin
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end else begin
      passCount++;
    end
  endtask

  function automatic logic [DW-1:0] mkWord(input int src, input int testId, input int seq);
    return (64'(src) << 56) | (64'(testId) << 48) | 64'(seq);
  endfunction

  // Present the modelled FIFO heads and empty flags to the DUT.
  task automatic refreshFifos();
    for (int i = 0; i < NUM_IN; i++) begin
      fifo_empty_i[i] = (fifoCnt[i] == 0);
      fifo_data_i[i*DW +: DW] = (fifoCnt[i] != 0) ? fifoMem[i][fifoHead[i]] : '0;
    end
  endtask

  task automatic clearFifos();
    for (int i = 0; i < NUM_IN; i++) begin
      fifoHead[i] = 0;
      fifoCnt[i]  = 0;
    end
    refreshFifos();
  endtask

  // Append n tagged words to one FIFO. Optionally queue them as expected
  // output when the load order already matches the grant order.
  task automatic applyStimulus(input int src, input int n, input int testId, input bit pushExp);
    logic [DW-1:0] w;
    for (int k = 0; k < n; k++) begin
      w = mkWord(src, testId, k);
      fifoMem[src][fifoHead[src] + fifoCnt[src]] = w;
      fifoCnt[src]++;
      if (pushExp) expQ.push_back(w);
    end
    refreshFifos();
  endtask

  // One clock cycle. Outputs are sampled on the falling edge, and the pop
  // legality and scoreboard are checked there. Consumed words are retired
  // from the FIFO model just after the rising edge.
  task automatic tick();
    logic          legal;
    logic [DW-1:0] expWord;
    @(negedge clk_i);
    lastConsume = fifo_consume_o;
    lastValid   = out_valid_o;
    lastBusy    = busy_o;
    lastData    = out_data_o;
    if (lastConsume != '0) begin
      legal = $onehot(lastConsume);
      for (int i = 0; i < NUM_IN; i++) begin
        if (lastConsume[i] && fifoCnt[i] == 0) legal = 1'b0;
      end
      checkOutput("consumeLegal", 64'(legal), 64'd1);
    end
    if (out_valid_o && out_ready_i) begin
      if (expQ.size() == 0) begin
        checkOutput("sbExtraWord", out_data_o, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        expWord = expQ.pop_front();
        checkOutput("sbData", out_data_o, expWord);
        checkOutput("sbSrc", 64'(out_src_o), expWord >> 56);
      end
    end
    @(posedge clk_i);
    #1;
    for (int i = 0; i < NUM_IN; i++) begin
      if (lastConsume[i] && fifoCnt[i] > 0) begin
        fifoHead[i]++;
        fifoCnt[i]--;
      end
    end
    refreshFifos();
  endtask

  task automatic doReset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    repeat (4) tick();
    checkOutput(tag, 64'(expQ.size()), 64'd0);
  endtask

  logic [NUM_IN-1:0] t2Cons [10] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0};
  logic              t4Rdy  [14] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                     1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [NUM_IN-1:0] t4Cons [14] = '{4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
                                     4'h2, 4'h2, 4'h0, 4'h2, 4'h2, 4'h0};
  logic [NUM_IN-1:0] t5Cons [12] = '{4'h0, 4'h4, 4'h4, 4'h0, 4'h0, 4'h8, 4'h8, 4'h0,
                                     4'h0, 4'h1, 4'h1, 4'h0};
  logic [NUM_IN-1:0] t6Cons [13] = '{4'h0, 4'h2, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0,
                                     4'h2, 4'h2, 4'h2, 4'h0, 4'h0};

  initial begin
    int cycles;
    int leftover;
    checkCount  = 0;
    passCount   = 0;
    rst_i       = 1'b1;
    out_ready_i = 1'b1;
    fifo_data_i = '0;
    clearFifos();
    @(posedge clk_i);
    #1;

    // Test 1: reset held with every FIFO non-empty -> no pops, idle outputs.
    for (int s = 0; s < NUM_IN; s++) applyStimulus(s, 1, 1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("t1Consume", 64'(lastConsume), 64'd0);
      checkOutput("t1Valid", 64'(lastValid), 64'd0);
      checkOutput("t1Busy", 64'(lastBusy), 64'd0);
    end
    clearFifos();
    tick();
    rst_i = 1'b0;

    // Test 2: sole requester with 6 words -> burst of 4, gap, re-grant, 2 more.
    applyStimulus(0, 6, 2, 1'b1);
    for (int c = 0; c < 10; c++) begin
      tick();
      checkOutput("t2Consume", 64'(lastConsume), 64'(t2Cons[c]));
    end
    drain("t2Drained");

    // Test 3: all FIFOs hold 8 words -> bursts of 4 in order 0,1,2,3,0,1,2,3.
    doReset();
    for (int s = 0; s < NUM_IN; s++) applyStimulus(s, 8, 3, 1'b0);
    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < NUM_IN; s++) begin
        for (int k = 0; k < BLEN; k++) expQ.push_back(mkWord(s, 3, r*BLEN + k));
      end
    end
    cycles = 0;
    while (expQ.size() != 0 && cycles < 100) begin
      tick();
      cycles++;
    end
    checkOutput("t3AllWords", 64'(expQ.size()), 64'd0);
    leftover = 0;
    for (int s = 0; s < NUM_IN; s++) leftover += fifoCnt[s];
    checkOutput("t3FifosEmpty", 64'(leftover), 64'd0);
    drain("t3Drained");

    // Test 4: output stalls for 5 cycles mid-burst; the burst still totals 4.
    doReset();
    applyStimulus(1, 6, 4, 1'b1);
    for (int c = 0; c < 14; c++) begin
      out_ready_i = t4Rdy[c];
      tick();
      checkOutput("t4Consume", 64'(lastConsume), 64'(t4Cons[c]));
      if (!t4Rdy[c]) begin
        checkOutput("t4HoldData", lastData, mkWord(1, 4, 1));
        checkOutput("t4HoldValid", 64'(lastValid), 64'd1);
      end
    end
    out_ready_i = 1'b1;
    drain("t4Drained");

    // Test 5: FIFO2 drains after 2 words. FIFO0 arrives mid-burst, but the
    // pointer now favours FIFO3.
    doReset();
    applyStimulus(2, 2, 5, 1'b1);
    applyStimulus(3, 2, 5, 1'b1);
    for (int c = 0; c < 12; c++) begin
      tick();
      checkOutput("t5Consume", 64'(lastConsume), 64'(t5Cons[c]));
      if (c == 1) applyStimulus(0, 2, 5, 1'b1);
    end
    drain("t5Drained");

    // Test 6: reset during the 2nd word of a FIFO1 burst (pointer starts at 1).
    // The grant is dropped, and the pointer restarts at 0, so FIFO0 wins next.
    applyStimulus(1, 4, 6, 1'b0);
    applyStimulus(0, 2, 6, 1'b0);
    expQ.push_back(mkWord(1, 6, 0));
    expQ.push_back(mkWord(0, 6, 0));
    expQ.push_back(mkWord(0, 6, 1));
    for (int k = 1; k < 4; k++) expQ.push_back(mkWord(1, 6, k));
    for (int c = 0; c < 13; c++) begin
      rst_i = (c == 2);
      tick();
      checkOutput("t6Consume", 64'(lastConsume), 64'(t6Cons[c]));
      if (c == 3) begin
        checkOutput("t6ValidAfterRst", 64'(lastValid), 64'd0);
        checkOutput("t6BusyAfterRst", 64'(lastBusy), 64'd0);
      end
    end
    rst_i = 1'b0;
    drain("t6Drained");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
